// File: rtl/connect4_win_checker.sv
// Connect-4 win checker: walks the four lines through the last-placed piece,
// one cell per clock, and reports win, draw or a malformed request.
module connect4_win_checker #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     Resetn,
    input  logic                     start,
    input  logic [2*ROWS*COLS-1:0]   board_flat,
    input  logic [2:0]               last_row,
    input  logic [2:0]               last_col,
    input  logic [1:0]               player,
    output logic                     busy,
    output logic                     done,
    output logic                     win,
    output logic                     draw,
    output logic                     bad_req
);

    localparam int CELLS = ROWS * COLS;
    localparam logic signed [4:0] ROWS_S = 5'(ROWS);
    localparam logic signed [4:0] COLS_S = 5'(COLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [2*CELLS-1:0]   board_r;
    logic [2:0]           row_r;
    logic [2:0]           col_r;
    logic [1:0]           player_r;
    logic [1:0]           dir_r;
    logic                 bwd_r;
    logic [2:0]           k_r;
    logic [2:0]           count_r;

    logic signed [4:0]    k_s;
    logic signed [4:0]    dr_s;
    logic signed [4:0]    dc_s;
    logic signed [4:0]    tr_s;
    logic signed [4:0]    tc_s;
    logic                 in_bounds_s;
    logic [6:0]           idx_s;
    logic                 match_s;
    logic                 win_hit_s;
    logic                 k_last_s;
    logic                 req_bad_s;
    logic                 full_s;
    logic [2:0]           count_inc_s;

    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input logic [6:0] idx);
        logic [1:0] c;
        c = 2'b00;
        for (int i = 0; i < CELLS; i++) begin
            if (idx == 7'(i)) begin
                c = b[2*i +: 2];
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    function automatic logic board_full(input logic [2*CELLS-1:0] b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            if (b[2*i +: 2] == 2'b00) begin
                f = 1'b0;
            end else begin
                f = f;
            end
        end
        return f;
    endfunction

    // Target cell of the current step and whether it extends the mover's run.
    always_comb begin
        k_s  = $signed({2'b00, k_r});
        dr_s = 5'sd0;
        dc_s = 5'sd0;
        case (dir_r)
            2'd0: dc_s = k_s;
            2'd1: dr_s = k_s;
            2'd2: begin dr_s = k_s; dc_s = k_s;  end
            2'd3: begin dr_s = k_s; dc_s = -k_s; end
            default: begin dr_s = 5'sd0; dc_s = 5'sd0; end
        endcase
        // Bounds are checked on the signed row/col so a step off one edge never wraps.
        tr_s        = $signed({2'b00, row_r}) + (bwd_r ? -dr_s : dr_s);
        tc_s        = $signed({2'b00, col_r}) + (bwd_r ? -dc_s : dc_s);
        in_bounds_s = (tr_s >= 5'sd0) && (tr_s < ROWS_S) && (tc_s >= 5'sd0) && (tc_s < COLS_S);
        idx_s       = 7'(tr_s[2:0]) * 7'(COLS) + 7'(tc_s[2:0]);
        match_s     = in_bounds_s && (cell_at(board_r, idx_s) == player_r);
        count_inc_s = count_r + 3'd1;
        win_hit_s   = ({1'b0, count_r} + 4'd1) == 4'(WIN_LEN);
        k_last_s    = (k_r == 3'(WIN_LEN - 1));
        req_bad_s   = (last_row >= 3'(ROWS)) || (last_col >= 3'(COLS)) ||
                      !((player == 2'b01) || (player == 2'b10));
        full_s      = board_full(board_r);
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_r  <= IDLE;
            board_r  <= '0;
            row_r    <= 3'd0;
            col_r    <= 3'd0;
            player_r <= 2'b00;
            dir_r    <= 2'd0;
            bwd_r    <= 1'b0;
            k_r      <= 3'd1;
            count_r  <= 3'd1;
            busy     <= 1'b0;
            done     <= 1'b0;
            win      <= 1'b0;
            draw     <= 1'b0;
            bad_req  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        board_r  <= board_flat;
                        row_r    <= last_row;
                        col_r    <= last_col;
                        player_r <= player;
                        win      <= 1'b0;
                        draw     <= 1'b0;
                        dir_r    <= 2'd0;
                        bwd_r    <= 1'b0;
                        k_r      <= 3'd1;
                        count_r  <= 3'd1;
                        bad_req  <= req_bad_s;
                        state_r  <= req_bad_s ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    busy <= 1'b1;
                    if (match_s && win_hit_s) begin
                        count_r <= count_inc_s;
                        win     <= 1'b1;
                        draw    <= 1'b0;
                        state_r <= DONE;
                    end else if (match_s && !k_last_s) begin
                        count_r <= count_inc_s;
                        k_r     <= k_r + 3'd1;
                    end else begin
                        // A match at maximum reach still counts before the line is abandoned.
                        if (match_s) begin
                            count_r <= count_inc_s;
                        end
                        if (!bwd_r) begin
                            bwd_r <= 1'b1;
                            k_r   <= 3'd1;
                        end else if (dir_r != 2'd3) begin
                            dir_r   <= dir_r + 2'd1;
                            bwd_r   <= 1'b0;
                            k_r     <= 3'd1;
                            count_r <= 3'd1;
                        end else begin
                            win     <= 1'b0;
                            draw    <= full_s;
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
